// File: rtl/btn_toggle_driver.sv
// Push-button front-end: synchronizes and debounces a raw button, then emits
// one-cycle D pulses per accepted press and a one-cycle CLR pulse on long hold.
module btn_toggle_driver #(
   parameter int DB_CYCLES   = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic clk,
   input  logic RST,
   input  logic btn_in,
   output logic D,
   output logic CLR,
   output logic btn_level
);

   localparam int DB_W   = $clog2(DB_CYCLES) + 1;
   localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      PRESSED,
      HELD,
      DB_RELEASE
   } state_t;

   state_t              r_state;
   logic                r_s0;
   logic                r_s1;
   logic [DB_W-1:0]     r_db_cnt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic                r_d;
   logic                r_clr;
   logic                r_level;
   logic                w_btn_s;

   assign w_btn_s = r_s1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (RST) begin
         r_s0 <= 1'b0;
         r_s1 <= 1'b0;
      end else begin
         r_s0 <= btn_in;
         r_s1 <= r_s0;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state    <= IDLE;
         r_db_cnt   <= '0;
         r_hold_cnt <= '0;
         r_d        <= 1'b0;
         r_clr      <= 1'b0;
         r_level    <= 1'b0;
      end else begin
         // Pulses default low so any assertion lasts exactly one clock.
         r_d   <= 1'b0;
         r_clr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_btn_s) begin
                  r_state  <= DB_PRESS;
                  r_db_cnt <= '0;
               end
            end
            DB_PRESS: begin
               if (!w_btn_s) begin
                  r_state <= IDLE;
               end else if (r_db_cnt == DB_LAST) begin
                  r_state    <= PRESSED;
                  r_hold_cnt <= '0;
                  r_d        <= 1'b1;
                  r_level    <= 1'b1;
               end else begin
                  r_db_cnt <= r_db_cnt + DB_W'(1);
               end
            end
            PRESSED: begin
               if (!w_btn_s) begin
                  r_state  <= DB_RELEASE;
                  r_db_cnt <= '0;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  r_state <= HELD;
                  r_clr   <= 1'b1;
               end else begin
                  r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
               end
            end
            HELD: begin
               if (!w_btn_s) begin
                  r_state  <= DB_RELEASE;
                  r_db_cnt <= '0;
               end
            end
            DB_RELEASE: begin
               // A release bounce lands in HELD: no new D, and hold timing is over.
               if (w_btn_s) begin
                  r_state <= HELD;
               end else if (r_db_cnt == DB_LAST) begin
                  r_state <= IDLE;
                  r_level <= 1'b0;
               end else begin
                  r_db_cnt <= r_db_cnt + DB_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign D         = r_d;
   assign CLR       = r_clr;
   assign btn_level = r_level;

endmodule

// File: tb/tb_btn_toggle_driver.sv
// Bench for btn_toggle_driver: run-length button model checked every cycle,
// plus directed scenarios with hand-computed pulse edges.
module tb_btn_toggle_driver;

   localparam int DB   = 4;
   localparam int HOLD = 8;

   logic clk;
   logic RST;
   logic btn_in;
   logic D;
   logic CLR;
   logic btn_level;

   btn_toggle_driver #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
      .clk       (clk),
      .RST       (RST),
      .btn_in    (btn_in),
      .D         (D),
      .CLR       (CLR),
      .btn_level (btn_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: two-sample delay, then debounced level driven by run lengths
   // of identical synchronized samples; hold age counted while held steadily.
   bit m_valid = 1'b0;
   bit m_pipe [2];
   bit m_b;
   int m_ones, m_zeros, m_age;
   bit m_level, m_live, m_d, m_clr;

   always @(posedge clk) begin
      if (RST) begin
         m_valid  = 1'b1;
         m_pipe[0] = 1'b0;
         m_pipe[1] = 1'b0;
         m_ones = 0; m_zeros = 0; m_age = 0;
         m_level = 1'b0; m_live = 1'b0; m_d = 1'b0; m_clr = 1'b0;
      end else begin
         m_b       = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = (btn_in === 1'b1);
         m_d   = 1'b0;
         m_clr = 1'b0;
         if (m_b) begin m_ones++; m_zeros = 0; end
         else     begin m_zeros++; m_ones = 0; end
         if (!m_level) begin
            if (m_ones == DB + 1) begin
               m_level = 1'b1; m_d = 1'b1; m_age = 0; m_live = 1'b1;
            end
         end else if (!m_b) begin
            m_live = 1'b0;
            if (m_zeros == DB + 1) m_level = 1'b0;
         end else if (m_live) begin
            m_age++;
            if (m_age == HOLD) begin m_clr = 1'b1; m_live = 1'b0; end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("D", D, m_d);
         check("CLR", CLR, m_clr);
         check("btn_level", btn_level, m_level);
      end
   end

   // Directed-scenario monitor; rel is the edge index since start().
   int rel, d_cnt, clr_cnt, d_rel, clr_rel, rise_cnt, fall_cnt, rise_rel, fall_rel;
   logic prev_level;

   task automatic start();
      rel = -1;
      d_cnt = 0; clr_cnt = 0; rise_cnt = 0; fall_cnt = 0;
      d_rel = -1; clr_rel = -1; rise_rel = -1; fall_rel = -1;
      prev_level = btn_level;
   endtask

   task automatic step(input logic b, input logic r);
      btn_in = b;
      RST    = r;
      @(negedge clk);
      rel++;
      if (D === 1'b1)   begin d_cnt++;   d_rel = rel;   end
      if (CLR === 1'b1) begin clr_cnt++; clr_rel = rel; end
      if (btn_level === 1'b1 && prev_level !== 1'b1) begin rise_cnt++; rise_rel = rel; end
      if (btn_level === 1'b0 && prev_level === 1'b1) begin fall_cnt++; fall_rel = rel; end
      prev_level = btn_level;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   logic rb;
   int   len;

   initial begin
      RST    = 1'b1;
      btn_in = 1'b0;
      repeat (2) @(negedge clk);

      // Reset held with button pressed, then fresh press after release of RST.
      start();
      repeat (3) begin
         step(1'b1, 1'b1);
         check("rst_D", D, 0);
         check("rst_CLR", CLR, 0);
         check("rst_level", btn_level, 0);
      end
      start();
      repeat (12) step(1'b1, 1'b0);
      check("rst_exit_d_edge", d_rel, 6);
      check("rst_exit_d_count", d_cnt, 1);
      repeat (20) step(1'b0, 1'b0);

      // Clean short press.
      start();
      repeat (10) step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);
      check("short_d_edge", d_rel, 6);
      check("short_d_count", d_cnt, 1);
      check("short_clr_count", clr_cnt, 0);
      check("short_rise_edge", rise_rel, 6);
      check("short_fall_edge", fall_rel, 16);

      // Press bounce.
      start();
      repeat (10) begin
         repeat (3) step(1'b1, 1'b0);
         repeat (2) step(1'b0, 1'b0);
      end
      repeat (8) step(1'b0, 1'b0);
      check("bounce_d_count", d_cnt, 0);
      check("bounce_clr_count", clr_cnt, 0);
      check("bounce_rise_count", rise_cnt, 0);

      // Minimum press boundary: four high samples rejected, five accepted.
      start();
      repeat (4) step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
      check("min4_d_count", d_cnt, 0);
      check("min4_rise_count", rise_cnt, 0);
      start();
      repeat (5) step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);
      check("min5_d_count", d_cnt, 1);
      check("min5_d_edge", d_rel, 6);
      check("min5_fall_edge", fall_rel, 11);

      // Long hold.
      start();
      repeat (30) step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);
      check("hold_d_edge", d_rel, 6);
      check("hold_clr_edge", clr_rel, 14);
      check("hold_d_count", d_cnt, 1);
      check("hold_clr_count", clr_cnt, 1);
      check("hold_fall_edge", fall_rel, 36);

      // Release bounce after D.
      start();
      repeat (7) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);
      check("relb_d_count", d_cnt, 1);
      check("relb_clr_count", clr_cnt, 0);
      check("relb_fall_count", fall_cnt, 1);
      check("relb_fall_edge", fall_rel, 20);

      // Reset mid-hold, then a fresh press and hold.
      start();
      repeat (10) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("midrst_level", btn_level, 0);
      check("midrst_D", D, 0);
      check("midrst_CLR", CLR, 0);
      step(1'b1, 1'b1);
      start();
      repeat (16) step(1'b1, 1'b0);
      check("midrst_d_edge", d_rel, 6);
      check("midrst_clr_edge", clr_rel, 14);
      check("midrst_d_count", d_cnt, 1);
      check("midrst_clr_count", clr_cnt, 1);
      repeat (12) step(1'b0, 1'b0);

      // Random runs of bouncing and steady levels with occasional resets.
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 29) == 0) begin
            rb = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) step(rb, 1'b1);
         end
         rb  = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 25) : $urandom_range(1, 7);
         repeat (len) step(rb, 1'b0);
      end
      repeat (12) step(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
